gshare_update_queue: RTL and testbench

Buffers resolved conditional-branch outcomes from the branch execution unit and drains them, one per cycle, into the PHT write port (`we`/`wcond`/`went`) of `gshare_predictor`. It decouples branch resolution from the PHT update. It discards outcomes from branches squashed by a misprediction before they reach the PHT. It sits between the branch unit (upstream) and the gshare predictor (downstream).

---
 rtl/gshare_update_queue_if.sv | 24 ++
 rtl/gshare_update_queue.sv | 94 +++++++++
 tb/tb_gshare_update_queue.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gshare_update_queue_if.sv
// Branch-unit to update-queue handshake: one resolved conditional branch per transfer.
// Latency: none, wiring only.
// Backpressure: in_ready from the queue; a transfer happens when in_valid & in_ready.
`ifndef GSH_PHT_SEL
`define GSH_PHT_SEL 10
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

interface gshare_update_queue_if;
  logic                    in_valid;
  logic                    in_cond;
  logic [`GSH_PHT_SEL-1:0] in_went;
  logic [`SPECTAG_LEN-1:0] in_spectag;
  logic                    in_ready;

  // branch execution unit side
  modport master (output in_valid, output in_cond, output in_went, output in_spectag,
                  input in_ready);
  // update queue side
  modport slave (input in_valid, input in_cond, input in_went, input in_spectag,
                 output in_ready);
endinterface

// File: rtl/gshare_update_queue.sv
// Circular queue of resolved branch outcomes draining one per cycle into the gshare PHT write port.
// Latency: an entry accepted at edge t drives we during cycle t+1 when the queue is empty.
// Backpressure: in_ready drops only when all DEPTH slots are occupied; the PHT side never stalls.
`ifndef GSH_PHT_SEL
`define GSH_PHT_SEL 10
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

module gshare_update_queue #(
  parameter int DEPTH   = 4,
  parameter int PTR_LEN = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  gshare_update_queue_if.slave    bu,
  input  logic                    prmiss,
  input  logic [`SPECTAG_LEN-1:0] kill_mask,
  output logic                    we,
  output logic                    wcond,
  output logic [`GSH_PHT_SEL-1:0] went,
  output logic [PTR_LEN:0]        count
);

  localparam logic [PTR_LEN:0]   FULL_CNT = DEPTH[PTR_LEN:0];
  localparam logic [PTR_LEN-1:0] PTR_ONE  = PTR_LEN'(1);

  logic                    ent_valid [DEPTH];
  logic                    ent_cond  [DEPTH];
  logic [`GSH_PHT_SEL-1:0] ent_went  [DEPTH];
  logic [`SPECTAG_LEN-1:0] ent_tag   [DEPTH];

  logic [PTR_LEN-1:0] head;
  logic [PTR_LEN-1:0] tail;

  logic push;
  logic pop;
  logic push_killed;

  // All handshake and write-port outputs come from registers only; the head
  // is consumed unconditionally whenever anything (even a killed hole) is held.
  assign bu.in_ready  = (count != FULL_CNT);
  assign push         = bu.in_valid & bu.in_ready;
  assign pop          = (count != '0);
  assign push_killed  = prmiss & (|(bu.in_spectag & kill_mask));

  assign we    = pop & ent_valid[head];
  assign wcond = pop ? ent_cond[head] : 1'b0;
  assign went  = pop ? ent_went[head] : '0;

  // Pointers, occupancy and per-entry valid bits; kill clears matching entries,
  // and a push into the tail slot (never a live entry) takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
    end else begin
      if (prmiss) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (|(ent_tag[i] & kill_mask)) begin
            ent_valid[i] <= 1'b0;
          end
        end
      end
      if (push) begin
        ent_valid[tail] <= ~push_killed;
        tail            <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; only meaningful while the slot is occupied, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_cond[tail] <= bu.in_cond;
      ent_went[tail] <= bu.in_went;
      ent_tag[tail]  <= bu.in_spectag;
    end
  end

endmodule

// File: tb/tb_gshare_update_queue.sv
// Directed bench for gshare_update_queue with an in-order expected-output scoreboard.
// Latency: each pushed entry is expected on the write port right after its accepting edge.
// Backpressure: the full interlock is reached by forcing the occupancy register.
`ifndef GSH_PHT_SEL
`define GSH_PHT_SEL 10
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

module tb_gshare_update_queue;

  typedef struct packed {
    logic                    we;
    logic                    cond;
    logic [`GSH_PHT_SEL-1:0] went;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    prmiss;
  logic [`SPECTAG_LEN-1:0] kill_mask;
  logic                    we;
  logic                    wcond;
  logic [`GSH_PHT_SEL-1:0] went;
  logic [2:0]              count;

  gshare_update_queue_if ifc ();

  gshare_update_queue #(.DEPTH(4), .PTR_LEN(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bu        (ifc.slave),
    .prmiss    (prmiss),
    .kill_mask (kill_mask),
    .we        (we),
    .wcond     (wcond),
    .went      (went),
    .count     (count)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compare the write port against the oldest expected entry, or idle if none.
  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_we"},    32'(we),    32'(e.we));
      chk({tag, "_wcond"}, 32'(wcond), 32'(e.cond));
      chk({tag, "_went"},  32'(went),  32'(e.went));
    end else begin
      chk({tag, "_idle_we"},    32'(we),    32'd0);
      chk({tag, "_idle_wcond"}, 32'(wcond), 32'd0);
      chk({tag, "_idle_went"},  32'(went),  32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic [`GSH_PHT_SEL-1:0] w,
                       input logic [`SPECTAG_LEN-1:0] t);
    ifc.in_valid   = v;
    ifc.in_cond    = c;
    ifc.in_went    = w;
    ifc.in_spectag = t;
  endtask

  initial begin
    reset     = 1'b1;
    prmiss    = 1'b0;
    kill_mask = '0;
    drive(1'b1, 1'b1, 10'h3FF, 5'b00001);

    // reset with a push offered: nothing may be stored
    cycle();
    cycle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_we",    32'(we), 32'd0);
    chk("rst_went",  32'(went), 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    cycle();
    check_out("rst_idle");
    chk("rst_idle_count", 32'(count), 32'd0);

    // single pass-through
    drive(1'b1, 1'b1, 10'h02A, 5'b00010);
    exp_q.push_back('{we: 1'b1, cond: 1'b1, went: 10'h02A});
    cycle();
    check_out("single");
    drive(1'b0, 1'b0, '0, '0);
    cycle();
    check_out("single_after");
    chk("single_count", 32'(count), 32'd0);

    // back-to-back stream of 10 with pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i[0], 10'(i), 5'b00100);
      exp_q.push_back('{we: 1'b1, cond: i[0], went: 10'(i)});
      cycle();
      check_out("stream");
      chk("stream_count", 32'(count), 32'd1);
    end
    drive(1'b0, 1'b0, '0, '0);
    cycle();
    check_out("stream_end");
    chk("stream_end_count", 32'(count), 32'd0);

    // fill with pops stalled, kill tag 00001, then drain
    force dut.count = 3'd0;
    drive(1'b1, 1'b1, 10'h101, 5'b00001); cycle(); check_out("fill0");
    drive(1'b1, 1'b0, 10'h102, 5'b00100); cycle(); check_out("fill1");
    drive(1'b1, 1'b1, 10'h103, 5'b00001); cycle(); check_out("fill2");
    drive(1'b1, 1'b1, 10'h104, 5'b00010); cycle(); check_out("fill3");
    drive(1'b0, 1'b0, '0, '0);
    prmiss    = 1'b1;
    kill_mask = 5'b00001;
    cycle();
    check_out("kill_cycle");
    prmiss    = 1'b0;
    kill_mask = '0;
    force dut.count = 3'd4;
    release dut.count;
    #1;
    exp_q.push_back('{we: 1'b0, cond: 1'b1, went: 10'h101});
    exp_q.push_back('{we: 1'b1, cond: 1'b0, went: 10'h102});
    exp_q.push_back('{we: 1'b0, cond: 1'b1, went: 10'h103});
    exp_q.push_back('{we: 1'b1, cond: 1'b1, went: 10'h104});
    check_out("drain0");
    chk("full_ready", 32'(ifc.in_ready), 32'd0);
    drive(1'b1, 1'b1, 10'h3AA, 5'b00000);
    cycle();
    check_out("drain1");
    drive(1'b0, 1'b0, '0, '0);
    chk("full_refused_count", 32'(count), 32'd3);
    cycle();
    check_out("drain2");
    cycle();
    check_out("drain3");
    cycle();
    check_out("drain_end");
    chk("drain_end_count", 32'(count), 32'd0);

    // kill of same-cycle push while the head carries the same tag
    drive(1'b1, 1'b1, 10'h011, 5'b01000);
    exp_q.push_back('{we: 1'b1, cond: 1'b1, went: 10'h011});
    cycle();
    check_out("hk_head");
    drive(1'b1, 1'b0, 10'h022, 5'b01000);
    prmiss    = 1'b1;
    kill_mask = 5'b01000;
    #1;
    chk("hk_head_we_in_kill", 32'(we), 32'd1);
    exp_q.push_back('{we: 1'b0, cond: 1'b0, went: 10'h022});
    cycle();
    check_out("hk_push");
    drive(1'b0, 1'b0, '0, '0);
    prmiss    = 1'b0;
    kill_mask = '0;
    cycle();
    check_out("hk_end");

    // reset with three entries held
    force dut.count = 3'd0;
    drive(1'b1, 1'b1, 10'h031, 5'b00000); cycle(); check_out("mr_fill0");
    drive(1'b1, 1'b0, 10'h032, 5'b00000); cycle(); check_out("mr_fill1");
    drive(1'b1, 1'b1, 10'h033, 5'b00000); cycle(); check_out("mr_fill2");
    drive(1'b0, 1'b0, '0, '0);
    force dut.count = 3'd3;
    release dut.count;
    #1;
    chk("mr_pre_we", 32'(we), 32'd1);
    reset = 1'b1;
    drive(1'b1, 1'b1, 10'h0EE, 5'b00000);
    cycle();
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_we",    32'(we), 32'd0);
    chk("mr_ready", 32'(ifc.in_ready), 32'd1);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_out("mr_after");
      chk("mr_after_count", 32'(count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
